// File: rtl/scablk_mgr_if.sv
// scablk_mgr_if: control strobes and status bundle of the SCA block manager.
// master drives the strobes, slave (the manager) drives the status.
interface scablk_mgr_if #(
    parameter int ABITS  = 4,
    parameter int LDEPTH = 8,
    parameter int RDEPTH = 4
);
    logic                      lct;
    logic                      dcd_vld;
    logic                      dcd_match;
    logic                      rd_done;
    logic                      rdav;
    logic [ABITS-1:0]          rdblk;
    logic                      rdscafull;
    logic [ABITS:0]            nfree;
    logic [$clog2(LDEPTH):0]   npend;
    logic [$clog2(RDEPTH):0]   nrdq;
    logic                      scafull;
    logic [3:0]                err;

    modport master (
        output lct, dcd_vld, dcd_match, rd_done,
        input  rdav, rdblk, rdscafull, nfree, npend, nrdq, scafull, err
    );

    modport slave (
        input  lct, dcd_vld, dcd_match, rd_done,
        output rdav, rdblk, rdscafull, nfree, npend, nrdq, scafull, err
    );
endinterface

// File: rtl/scablk_mgr.sv
// scablk_mgr: SCA block free pool with pending (LCT) and readout queues.
// Define SCABLK_TMO_EN to enable the pending-head decision timeout.
module scablk_mgr #(
    parameter int NBLK    = 16,
    parameter int ABITS   = 4,
    parameter int LDEPTH  = 8,
    parameter int RDEPTH  = 4,
    parameter int TMO_CYC = 512
) (
    input logic          CLK,
    input logic          RST_B,
    scablk_mgr_if.slave  bus
);
    localparam int LPW = $clog2(LDEPTH);
    localparam int RPW = $clog2(RDEPTH);

    typedef struct packed {
        logic [ABITS-1:0] blk;
        logic             flag;
    } ent_t;

    logic [NBLK-1:0]  pool_q, pool_n;
    logic [ABITS:0]   nfree_q, nfree_n;
    logic [ABITS-1:0] last_q, last_n;
    logic [3:0]       err_q, err_n;

    ent_t             pq_mem [LDEPTH];
    logic [LPW-1:0]   pq_wp_q, pq_rp_q;
    logic [LPW:0]     pq_cnt_q, pq_cnt_n;

    ent_t             rq_mem [RDEPTH];
    logic [RPW-1:0]   rq_wp_q, rq_rp_q, rp_n;
    logic [RPW:0]     rq_cnt_q, rq_cnt_n;

    logic             rdav_q, rdav_n;
    ent_t             rdh_q, rdh_n;
    logic             scafull_q;

    logic             alloc_ok;
    logic [ABITS-1:0] alloc_blk;
    logic             pq_empty, pq_full, rq_empty, rq_full;
    ent_t             pq_head, rq_head, push_ent;
    logic             tmo_hit;
    logic             pq_pop, pq_push, rq_pop, rq_push;
    logic             match, alloc, free_dec, free_rd;

    // Lowest-index free block from the pool as registered at cycle start
    always_comb begin
        alloc_ok  = 1'b0;
        alloc_blk = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (pool_q[i]) begin
                alloc_ok  = 1'b1;
                alloc_blk = ABITS'(i);
            end
        end
    end

    assign pq_empty = (pq_cnt_q == '0);
    assign pq_full  = (pq_cnt_q == (LPW+1)'(LDEPTH));
    assign rq_empty = (rq_cnt_q == '0);
    assign rq_full  = (rq_cnt_q == (RPW+1)'(RDEPTH));
    assign pq_head  = pq_mem[pq_rp_q];
    assign rq_head  = rq_mem[rq_rp_q];

`ifdef SCABLK_TMO_EN
    localparam int TW = $clog2(TMO_CYC) + 1;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            tmo_q <= '0;
        end else if (pq_pop || pq_empty) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // An explicit decision in the same cycle wins over the timeout
    assign tmo_hit = !pq_empty && !bus.dcd_vld &&
                     (tmo_q == TW'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        match    = bus.dcd_vld && bus.dcd_match;
        pq_pop   = (bus.dcd_vld && !pq_empty) || tmo_hit;
        rq_pop   = bus.rd_done && !rq_empty;
        pq_push  = bus.lct && (!pq_full || pq_pop);
        rq_push  = pq_pop && match && (!rq_full || rq_pop);
        alloc    = pq_push && alloc_ok;
        free_dec = pq_pop && !rq_push && !pq_head.flag;
        free_rd  = rq_pop && !rq_head.flag;

        // With the pool exhausted the last block is overwritten
        push_ent.blk  = alloc ? alloc_blk : last_q;
        push_ent.flag = !alloc;

        pool_n = pool_q;
        if (alloc)    pool_n[alloc_blk]   = 1'b0;
        if (free_dec) pool_n[pq_head.blk] = 1'b1;
        if (free_rd)  pool_n[rq_head.blk] = 1'b1;

        nfree_n = nfree_q
                + (ABITS+1)'(free_dec)
                + (ABITS+1)'(free_rd)
                - (ABITS+1)'(alloc);
        last_n  = alloc ? alloc_blk : last_q;

        pq_cnt_n = pq_cnt_q + (LPW+1)'(pq_push) - (LPW+1)'(pq_pop);
        rq_cnt_n = rq_cnt_q + (RPW+1)'(rq_push) - (RPW+1)'(rq_pop);

        err_n    = err_q;
        err_n[0] = err_q[0] | (bus.lct && !pq_push);
        err_n[1] = err_q[1] | (bus.dcd_vld && pq_empty);
        err_n[2] = err_q[2] | (pq_pop && match && !rq_push);
        err_n[3] = err_q[3] | tmo_hit;

        // Next readout head, taking a same-cycle write into that slot
        rp_n   = rq_rp_q + RPW'(rq_pop);
        rdav_n = (rq_cnt_n != '0);
        rdh_n  = '0;
        if (rdav_n) begin
            if (rq_push && (rq_wp_q == rp_n)) rdh_n = pq_head;
            else                              rdh_n = rq_mem[rp_n];
        end
    end

    always_ff @(posedge CLK) begin
        if (pq_push) pq_mem[pq_wp_q] <= push_ent;
        if (rq_push) rq_mem[rq_wp_q] <= pq_head;
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            pool_q    <= '1;
            nfree_q   <= (ABITS+1)'(NBLK);
            last_q    <= '0;
            err_q     <= '0;
            pq_wp_q   <= '0;
            pq_rp_q   <= '0;
            pq_cnt_q  <= '0;
            rq_wp_q   <= '0;
            rq_rp_q   <= '0;
            rq_cnt_q  <= '0;
            rdav_q    <= 1'b0;
            rdh_q     <= '0;
            scafull_q <= 1'b0;
        end else begin
            pool_q    <= pool_n;
            nfree_q   <= nfree_n;
            last_q    <= last_n;
            err_q     <= err_n;
            pq_wp_q   <= pq_wp_q + LPW'(pq_push);
            pq_rp_q   <= pq_rp_q + LPW'(pq_pop);
            pq_cnt_q  <= pq_cnt_n;
            rq_wp_q   <= rq_wp_q + RPW'(rq_push);
            rq_rp_q   <= rp_n;
            rq_cnt_q  <= rq_cnt_n;
            rdav_q    <= rdav_n;
            rdh_q     <= rdh_n;
            scafull_q <= (nfree_n == '0);
        end
    end

    assign bus.rdav      = rdav_q;
    assign bus.rdblk     = rdh_q.blk;
    assign bus.rdscafull = rdh_q.flag;
    assign bus.nfree     = nfree_q;
    assign bus.npend     = pq_cnt_q;
    assign bus.nrdq      = rq_cnt_q;
    assign bus.scafull   = scafull_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_scablk_mgr.sv
// tb_scablk_mgr: directed checks of allocation, queues, errors and reset.
// A second instance with a deep pending queue covers pool exhaustion.
module tb_scablk_mgr;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    scablk_mgr_if #(.ABITS(4), .LDEPTH(8), .RDEPTH(4)) b0 ();
    scablk_mgr_if #(.ABITS(4), .LDEPTH(32), .RDEPTH(4)) b1 ();

    scablk_mgr u0 (.CLK(clk), .RST_B(rst_b), .bus(b0));
    scablk_mgr #(.LDEPTH(32)) u1 (.CLK(clk), .RST_B(rst_b), .bus(b1));

`ifdef SCABLK_TMO_EN
    scablk_mgr_if #(.ABITS(4), .LDEPTH(8), .RDEPTH(4)) b2 ();
    scablk_mgr #(.TMO_CYC(16)) u2 (.CLK(clk), .RST_B(rst_b), .bus(b2));

    task automatic s2(input logic l);
        b2.lct = l;
        @(posedge clk);
        #1;
        b2.lct = 1'b0;
    endtask
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic s0(input logic l, input logic d, input logic m,
                      input logic r);
        b0.lct = l; b0.dcd_vld = d; b0.dcd_match = m; b0.rd_done = r;
        @(posedge clk);
        #1;
        b0.lct = 0; b0.dcd_vld = 0; b0.dcd_match = 0; b0.rd_done = 0;
    endtask

    task automatic s1(input logic l, input logic d, input logic m,
                      input logic r);
        b1.lct = l; b1.dcd_vld = d; b1.dcd_match = m; b1.rd_done = r;
        @(posedge clk);
        #1;
        b1.lct = 0; b1.dcd_vld = 0; b1.dcd_match = 0; b1.rd_done = 0;
    endtask

    task automatic st0(input string tag, input int nf, input int np,
                       input int nr, input int er);
        chk({tag, ".nfree"}, 32'(b0.nfree), nf);
        chk({tag, ".npend"}, 32'(b0.npend), np);
        chk({tag, ".nrdq"},  32'(b0.nrdq),  nr);
        chk({tag, ".err"},   32'(b0.err),   er);
    endtask

    task automatic rd0(input string tag, input int av, input int blk,
                       input int fl);
        chk({tag, ".rdav"},      32'(b0.rdav),      av);
        chk({tag, ".rdblk"},     32'(b0.rdblk),     blk);
        chk({tag, ".rdscafull"}, 32'(b0.rdscafull), fl);
    endtask

    initial begin
        b0.lct = 0; b0.dcd_vld = 0; b0.dcd_match = 0; b0.rd_done = 0;
        b1.lct = 0; b1.dcd_vld = 0; b1.dcd_match = 0; b1.rd_done = 0;
`ifdef SCABLK_TMO_EN
        b2.lct = 0; b2.dcd_vld = 0; b2.dcd_match = 0; b2.rd_done = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        st0("reset", 16, 0, 0, 0);
        rd0("reset", 0, 0, 0);
        chk("reset.scafull", 32'(b0.scafull), 0);
        chk("reset1.nfree", 32'(b1.nfree), 16);
        rst_b = 1'b1;

        repeat (3) s0(1, 0, 0, 0);
        st0("alloc3", 13, 3, 0, 0);
        s0(0, 1, 1, 0);
        st0("match", 13, 2, 1, 0);
        rd0("match", 1, 0, 0);
        s0(0, 1, 0, 0);
        st0("nomatch", 14, 1, 1, 0);
        s0(1, 0, 0, 0);
        st0("realloc", 13, 2, 1, 0);
        s0(0, 1, 1, 0);
        s0(0, 1, 1, 0);
        st0("mv2", 13, 0, 3, 0);
        s0(0, 0, 0, 1);
        st0("rd0", 14, 0, 2, 0);
        rd0("rd0", 1, 2, 0);
        s0(0, 0, 0, 1);
        st0("rd2", 15, 0, 1, 0);
        rd0("rd2", 1, 1, 0);
        s0(1, 0, 0, 0);
        st0("pre3", 14, 1, 1, 0);
        s0(1, 1, 1, 1);
        st0("tri", 14, 1, 1, 0);
        rd0("tri", 1, 0, 0);
        s0(0, 1, 0, 0);
        st0("drain", 15, 0, 1, 0);
        s0(0, 1, 0, 0);
        st0("nolct", 15, 0, 1, 2);
        s0(0, 0, 0, 1);
        st0("rdlast", 16, 0, 0, 2);
        rd0("rdlast", 0, 0, 0);
        s0(0, 0, 0, 1);
        st0("rdidle", 16, 0, 0, 2);

        repeat (8) s0(1, 0, 0, 0);
        st0("fill", 8, 8, 0, 2);
        s0(1, 1, 0, 0);
        st0("fullpp", 8, 8, 0, 2);
        s0(1, 0, 0, 0);
        st0("lctfull", 8, 8, 0, 3);
        repeat (4) s0(0, 1, 1, 0);
        st0("rqfill", 8, 4, 4, 3);
        rd0("rqfill", 1, 1, 0);
        s0(0, 1, 1, 0);
        st0("rqfull", 9, 3, 4, 7);
        s0(0, 1, 1, 1);
        st0("rqpp", 10, 2, 4, 7);
        rd0("rqpp", 1, 2, 0);

        rst_b = 1'b0;
        #1;
        st0("rstmid", 16, 0, 0, 0);
        rd0("rstmid", 0, 0, 0);
        chk("rstmid.scafull", 32'(b0.scafull), 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        repeat (15) s1(1, 0, 0, 0);
        chk("ex15.nfree", 32'(b1.nfree), 1);
        chk("ex15.scafull", 32'(b1.scafull), 0);
        s1(1, 0, 0, 0);
        chk("ex16.nfree", 32'(b1.nfree), 0);
        chk("ex16.scafull", 32'(b1.scafull), 1);
        s1(1, 0, 0, 0);
        chk("ex17.npend", 32'(b1.npend), 17);
        chk("ex17.nfree", 32'(b1.nfree), 0);
        chk("ex17.scafull", 32'(b1.scafull), 1);
        chk("ex17.err", 32'(b1.err), 0);
        repeat (16) s1(0, 1, 0, 0);
        chk("exdrain.nfree", 32'(b1.nfree), 16);
        chk("exdrain.npend", 32'(b1.npend), 1);
        s1(0, 1, 1, 0);
        chk("exflag.rdblk", 32'(b1.rdblk), 15);
        chk("exflag.rdscafull", 32'(b1.rdscafull), 1);
        chk("exflag.nfree", 32'(b1.nfree), 16);
        s1(0, 0, 0, 1);
        chk("exrd.nfree", 32'(b1.nfree), 16);
        chk("exrd.rdav", 32'(b1.rdav), 0);
        chk("exrd.rdscafull", 32'(b1.rdscafull), 0);

`ifdef SCABLK_TMO_EN
        s2(1);
        repeat (15) s2(0);
        chk("tmo15.npend", 32'(b2.npend), 1);
        chk("tmo15.nfree", 32'(b2.nfree), 15);
        s2(0);
        chk("tmo16.npend", 32'(b2.npend), 0);
        chk("tmo16.nfree", 32'(b2.nfree), 16);
        chk("tmo16.err", 32'(b2.err), 8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
